fp_result_sink: RTL and testbench
=================================

# fp_result_sink

Downstream result stage for the single-precision multiplier. It accepts packed IEEE-754 results over the multiplier's strobe/ack output handshake and classifies each result into special-value flags. It buffers the results in a small FIFO and presents them to a consumer over a valid/ready interface. It also keeps a saturating result counter and a sticky NaN status bit for debug and miter observation.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the result counter.
- clk  in  1  sole clock; every register updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_z  in  32  result word from the multiplier (its output_z).
- in_z_stb  in  1  multiplier result strobe (its output_z_stb).
- in_z_ack  out  1  drives the multiplier's output_z_ack.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  32  head result word.
- out_flags  out  5  head classification {nan, inf, zero, sub, sign}.
- result_count  out  CNT_W  number of accepted results; saturates at all-ones.
- nan_seen  out  1  sticky; set once any NaN has been accepted.

## Operation
- Storage: DEPTH×37-bit array holding {flags, word}.
- Pointers wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits wide.
- full = (count==DEPTH); empty = (count==0).
- in_z_ack = !full. It is derived from registered state only and is never a function of in_z_stb.
- Push: occurs when in_z_stb && in_z_ack at a clock edge.
  - Writes {flags(in_z), in_z} to mem[wr_ptr].
  - wr_ptr increments.
- Pop: occurs when out_valid && out_ready at a clock edge.
  - rd_ptr increments.
- count update per edge: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Classification of word w, with e = w[30:23] and m = w[22:0]:
  - nan = (e==8'hFF && m!=0).
  - inf = (e==8'hFF && m==0).
  - zero = (e==0 && m==0).
  - sub = (e==0 && m!=0).
  - sign = w[31].
  - At most one of nan, inf, zero or sub is set.
- out_valid = !empty.
- out_data and out_flags = mem[rd_ptr], read combinationally from the array.
- When empty, out_data and out_flags must still be 0 after reset. Every mem entry is cleared on reset.
- result_count increments on every push and holds at 2^CNT_W−1.
- nan_seen is set on any push whose nan flag is 1. It is cleared only by reset.
- Internal state is pointers plus count, with no further FSM. The block behaves as states EMPTY, PARTIAL and FULL:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on a push-only edge that makes count==DEPTH.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on a pop-only edge with count==1.

## Timing
- Reset, when rst_n is low at an edge, forces:
  - count=0 and both pointers=0.
  - every mem entry cleared.
  - result_count=0 and nan_seen=0.
  - in_z_ack=1, out_valid=0, out_data=0, out_flags=0.
- Reset overrides any push or pop sampled in the same edge.
- Reset in the middle of a transfer discards all buffered entries.
- Latency: a word pushed at edge t is visible on out_valid/out_data after edge t. This is one-cycle fall-through latency when empty.
- Throughput: one push and one pop per cycle, sustained.
- Full with simultaneous pop: in_z_ack is low, so no push occurs. The pop frees a slot, and in_z_ack rises after that edge.
- Empty with simultaneous push: no pop can occur, since out_valid is low.
- The multiplier drops its strobe one cycle after a handshake. A held in_z_stb with ack high is nevertheless treated as a fresh push each cycle, and the block does not deduplicate.
- out_data must remain stable while out_valid && !out_ready.

## Test plan
- Single result: push 0x40C00000 with out_ready=1.
  - out_valid=1 one cycle later with out_data=0x40C00000 and out_flags=5'b00000.
  - result_count=1.
- NaN and sticky: push 0x7FC00000.
  - out_flags=5'b10000 and nan_seen=1.
  - Then push 0x3F800000; nan_seen stays 1.
- Classification sweep:
  - 0xFF800000 → 5'b01001.
  - 0x80000000 → 5'b00101.
  - 0x00000001 → 5'b00010.
- Backpressure: out_ready=0 with DEPTH=4.
  - Push 1,2,3,4; in_z_ack=0 after the fourth push and a held strobe is not accepted.
  - Raise out_ready for one cycle: pops 1, and in_z_ack=1 the next cycle.
  - Data order out is 1,2,3,4 followed by the fifth word.
- Wrap and concurrent push/pop: stream 10 words with out_ready=1 continuously.
  - Output order matches input order.
  - count never exceeds 1.
  - Pointers wrap and result_count=10.
- Mid-operation reset: with 3 entries buffered, drive rst_n=0 for one edge.
  - out_valid=0, in_z_ack=1, result_count=0 and nan_seen=0.
  - The next push yields that word alone.

Source files
------------

// File: rtl/fp_result_sink_if.sv
// fp_result_sink_if: handshake bundle between the multiplier, the result sink and its consumer.
//   in_z / in_z_stb / in_z_ack       : multiplier result word, strobe, and the sink's acknowledge
//   out_data / out_flags / out_valid : head entry presented to the consumer
//   out_ready                        : consumer accepts the head entry
// Modport slave is the sink's view; modport master is the view of the surrounding logic.
interface fp_result_sink_if;
  logic [31:0] in_z;
  logic        in_z_stb;
  logic        in_z_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;

  modport slave (
    input  in_z,
    input  in_z_stb,
    output in_z_ack,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_flags
  );

  modport master (
    output in_z,
    output in_z_stb,
    input  in_z_ack,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_flags
  );
endinterface

// File: rtl/fp_result_sink.sv
// fp_result_sink: result stage behind the single-precision multiplier.
// Accepts packed IEEE-754 words over strobe/ack, tags each with special-value flags
// {nan, inf, zero, sub, sign}, buffers them in a DEPTH-entry FIFO and presents the head
// over valid/ready. Also keeps a saturating accepted-result counter and a sticky NaN bit.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : fp_result_sink_if.slave (input strobe/ack side, output valid/ready side)
//   result_count : accepted results, saturates at all-ones
//   nan_seen     : sticky, set once any NaN is accepted
module fp_result_sink #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_result_sink_if.slave    bus,
  output logic [CNT_W-1:0]   result_count,
  output logic               nan_seen
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [36:0]      r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic [CNT_W-1:0] r_result_count;
  logic             r_nan_seen;

  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic [4:0]  w_flags;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  // Classification of the incoming word.
  assign w_exp   = bus.in_z[30:23];
  assign w_man   = bus.in_z[22:0];
  assign w_flags = {(w_exp == 8'hFF) && (w_man != '0),
                    (w_exp == 8'hFF) && (w_man == '0),
                    (w_exp == 8'h00) && (w_man == '0),
                    (w_exp == 8'h00) && (w_man != '0),
                    bus.in_z[31]};

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);

  // Ack depends on registered occupancy only, so it never loops back through the strobe.
  assign bus.in_z_ack  = !w_full;
  assign bus.out_valid = !w_empty;
  assign w_push        = bus.in_z_stb && !w_full;
  assign w_pop         = !w_empty && bus.out_ready;

  // Head is read straight from the array; stable while stalled since rd_ptr only moves on pop.
  assign bus.out_data  = r_mem[r_rd_ptr][31:0];
  assign bus.out_flags = r_mem[r_rd_ptr][36:32];

  assign result_count = r_result_count;
  assign nan_seen     = r_nan_seen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_result_count <= '0;
      r_nan_seen     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_flags, bus.in_z};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (r_result_count != '1) begin
          r_result_count <= r_result_count + 1'b1;
        end
        if (w_flags[4]) begin
          r_nan_seen <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_result_sink.sv
// Scoreboard bench for fp_result_sink: directed scenarios followed by random traffic.
module tb_fp_result_sink;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] result_count;
  logic             nan_seen;

  fp_result_sink_if ifc ();

  fp_result_sink #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (ifc),
    .result_count (result_count),
    .nan_seen     (nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: queued words in order, occupancy, counter, sticky bit.
  logic [36:0] exp_q[$];
  int          m_occ   = 0;
  int          m_cnt   = 0;
  bit          m_nan   = 0;
  bit          m_fresh = 0;
  bit          live    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] classify(input logic [31:0] w);
    int unsigned e;
    int unsigned m;
    logic [4:0]  f;
    e = w[30:23];
    m = w[22:0];
    f = 5'b0;
    if (e == 255) f = (m != 0) ? 5'b10000 : 5'b01000;
    else if (e == 0) f = (m == 0) ? 5'b00100 : 5'b00010;
    f[0] = w[31];
    return f;
  endfunction

  // Monitor: every accepted head entry must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (live && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_expectation", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("out_data", ifc.out_data, e[31:0]);
        chk("out_flags", {27'b0, ifc.out_flags}, {27'b0, e[36:32]});
      end
    end
  end

  // Model: checks status outputs, then predicts the coming edge.
  always @(negedge clk) begin
    bit push;
    bit pop;
    #1;
    if (live) begin
      chk("in_z_ack", {31'b0, ifc.in_z_ack}, {31'b0, m_occ < DEPTH});
      chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, m_occ != 0});
      chk("result_count", {16'b0, result_count}, m_cnt);
      chk("nan_seen", {31'b0, nan_seen}, {31'b0, m_nan});
      if (m_fresh) begin
        chk("empty_out_data", ifc.out_data, 32'h0);
        chk("empty_out_flags", {27'b0, ifc.out_flags}, 32'h0);
      end
    end
    if (!rst_n) begin
      live    = 1;
      m_occ   = 0;
      m_cnt   = 0;
      m_nan   = 0;
      m_fresh = 1;
      exp_q.delete();
    end else if (live) begin
      push = ifc.in_z_stb && (m_occ < DEPTH);
      pop  = (m_occ > 0) && ifc.out_ready;
      if (push) begin
        logic [4:0] f;
        f = classify(ifc.in_z);
        exp_q.push_back({f, ifc.in_z});
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (f[4]) m_nan = 1;
        m_fresh = 0;
      end
      m_occ = m_occ + int'(push) - int'(pop);
    end
  end

  task automatic step(input logic stb, input logic [31:0] z, input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    ifc.in_z_stb  = stb;
    ifc.in_z      = z;
    ifc.out_ready = rdy;
    rst_n         = rst;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:23] = 8'hFF;
      1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
      2: w[30:23] = 8'h00;
      3: begin w[30:23] = 8'h00; w[22:0] = '0; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n         = 1'b0;
    ifc.in_z_stb  = 1'b0;
    ifc.in_z      = '0;
    ifc.out_ready = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);

    // Single result, NaN sticky, classification sweep.
    step(1, 32'h40C00000, 1, 1);
    step(0, 0, 1, 1);
    step(1, 32'h7FC00000, 1, 1);
    step(1, 32'h3F800000, 1, 1);
    step(1, 32'hFF800000, 1, 1);
    step(1, 32'h80000000, 1, 1);
    step(1, 32'h00000001, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);

    // Backpressure: fill, held strobe refused, one pop reopens ack.
    for (int i = 1; i <= 5; i++) step(1, i, 0, 1);
    step(1, 5, 0, 1);
    step(1, 5, 1, 1);
    step(1, 5, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

    // Streaming with continuous ready: pointers wrap, occupancy stays at one.
    for (int i = 0; i < 10; i++) step(1, 32'h1000 + i, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

    // Mid-operation reset with three entries buffered.
    for (int i = 0; i < 3; i++) step(1, 32'h7F800001 + i, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 32'hC0490FDB, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 3) != 0), 1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
    @(negedge clk);
    #2;
    chk("drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
